enc16to4_low: RTL and testbench
===============================

# enc16to4_low

Sequential active-low 16-line request encoder: the encode-side counterpart of the team's active-low 4-to-16 decoder. Each falling edge on one of 16 asynchronous active-low request lines is synchronised and held as a sticky pending bit. Pending requests are then granted one at a time as a 4-bit code with a valid/ack handshake. The block sits between external request sources and a consumer that services one numbered request per handshake.

## Interface
- SYNC_STAGES, 2, synchroniser depth on req_n; legal range 1..3.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  active-high enable; gates edge capture and new grants.
- req_n  input  16  asynchronous active-low request lines.
- ack  input  1  consumer accepts the current code; sampled only while valid=1.
- code  output  4  index of the granted request; stable while valid=1.
- valid  output  1  code is valid and awaiting ack.
- gs_n  output  1  group select; 0 while any pending bit is set.
- pend  output  16  active-high pending bits, for visibility.

## Operation
- Reset values:
  - synchroniser flops 16'hFFFF; edge-history register 16'hFFFF.
  - pend = 0, code = 0, valid = 0, gs_n = 1.
  - FSM = IDLE; round-robin pointer = 15.
- Synchroniser: req_n passes through SYNC_STAGES flops. The last stage is sync_q. prev_q is sync_q delayed by one clock.
- Edge capture: with en=1, pend[i] sets on the edge where sync_q[i]=0 and prev_q[i]=1. With en=0, edges are discarded. A line held low produces exactly one request and must rise again to re-request. A line held low across reset release counts as one fresh falling edge.
- gs_n is registered, equal to ~|pend of the next state.
- FSM IDLE:
  - Entered when en=1 and pend≠0.
  - Selects an index by the priority rule, registers it into code, sets valid=1 and moves to GRANT.
  - In the same edge, pend[index] clears unless a new falling edge on that line arrives in that cycle; set wins.
- FSM GRANT:
  - code and valid hold until ack=1 is sampled.
  - On that edge, valid←0 and the FSM returns to IDLE. code keeps its last value.
  - en falling during GRANT does not abort the grant.
- Priority, default: fixed, highest index wins (15 highest, 0 lowest).
- Pending bits are never dropped. A line re-edging while already pending stays one request; no overflow.

## Timing
- A request line sampled low at edge t0 (previously high) behaves as follows:
  - sync_q goes low after edge t0+SYNC_STAGES−1.
  - pend sets at edge t0+SYNC_STAGES.
  - valid rises at edge t0+SYNC_STAGES+1.
- ack: valid falls at the edge where ack=1 is sampled. The next valid rises at the following edge at the earliest.
  - Maximum throughput is one grant per 2 cycles.
  - ack held permanently high gives this 2-cycle rate.
- ack while valid=0 is ignored.
- Reset asserted mid-grant: all state clears immediately, asynchronously. Pending requests are lost.

## Configuration
- ENC_ROUND_ROBIN_EN defined:
  - Priority is round-robin. The search starts at the index after the pointer and wraps 15→0.
  - The pointer loads the granted index on each grant.
  - After reset the first search order is 0,1,…,15.
- ENC_ROUND_ROBIN_EN undefined: fixed highest-index priority. No pointer register is present.

## Structure
- Shared package/include enc_pkg holds:
  - N_LINES=16, CODE_W=4.
  - FSM state encodings IDLE=1'b0, GRANT=1'b1.
  - Reset constant 16'hFFFF for the synchroniser.
- Sub-module pri_enc16: purely combinational 16→4 priority encoder.
  - Inputs: pend and a 4-bit start index.
  - Outputs: index and any.
  - Fixed mode ties the start index to a constant selecting highest-first.
- Synchroniser, edge detect, pend register and FSM live in enc16to4_low.

## Test plan
- Reset, SYNC_STAGES=2, all req_n=1 → pend=0, valid=0, gs_n=1, code=0 held for 20 cycles.
- Single request:
  - Stimulus: req_n[5] driven 1→0 at edge t0, ack=0.
  - Required: pend[5] and gs_n=0 at t0+2; valid=1 with code=5 at t0+3; valid stays 1 and pend[5] stays 0 for 10 cycles.
  - Then ack=1 for one cycle → valid=0 and gs_n=1.
- Simultaneous requests, default build:
  - Stimulus: req_n lines 3, 9 and 12 fall together; ack=1 permanently.
  - Required: codes 12, 9, 3 on consecutive valid pulses, 2 cycles apart.
- Same stimulus with ENC_ROUND_ROBIN_EN → codes 3, 9, 12.
- Enable gating:
  - With en=0, req_n[7] falls → no pending bit and no valid.
  - en→1 with the line still low → no request.
  - The line rising and then falling again with en=1 → code=7.
- Reset mid-grant: rst_n pulsed low while valid=1 with code=4 and pend[2]=1 → all outputs at reset values immediately, and no grant after release while lines stay high.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and FSM state encoding for the active-low 16-line request encoder.
package enc_pkg;

  localparam int N_LINES = 16;
  localparam int CODE_W  = 4;

  localparam logic [N_LINES-1:0] SYNC_RST = 16'hFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/enc16to4_low_if.sv
// Request/grant bundle between request sources, the encoder and its consumer.
interface enc16to4_low_if;
  import enc_pkg::*;

  logic               en;
  logic [N_LINES-1:0] req_n;
  logic               ack;
  logic [CODE_W-1:0]  code;
  logic               valid;
  logic               gs_n;
  logic [N_LINES-1:0] pend;

  modport master (
    output en, req_n, ack,
    input  code, valid, gs_n, pend
  );

  modport slave (
    input  en, req_n, ack,
    output code, valid, gs_n, pend
  );

endinterface

// File: rtl/enc16to4_low_pri_enc16.sv
// Combinational 16->4 rotating priority encoder: the first set bit met when
// stepping from start (upward if ASCENDING, else downward, wrapping) wins.
module pri_enc16
  import enc_pkg::*;
#(
  parameter bit ASCENDING = 1'b0
) (
  input  logic [N_LINES-1:0] pend,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  index,
  output logic               any
);

  logic [CODE_W-1:0] cand;

  // Walk from the farthest candidate back to start so the nearest hit is written last.
  always_comb begin
    index = '0;
    cand  = '0;
    any   = |pend;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      cand = ASCENDING ? (start + CODE_W'(k)) : (start - CODE_W'(k));
      if (pend[cand]) begin
        index = cand;
      end
    end
  end

endmodule

// File: rtl/enc16to4_low.sv
// Active-low 16-line request encoder with sticky pending bits and valid/ack grants.
// Optional ENC_ROUND_ROBIN_EN selects round-robin instead of fixed highest-index priority.
module enc16to4_low
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  enc16to4_low_if.slave  bus
);

  logic [N_LINES-1:0] sync_reg [SYNC_STAGES];
  logic [N_LINES-1:0] sync_q;
  logic [N_LINES-1:0] prev_reg;
  logic [N_LINES-1:0] fall;
  logic [N_LINES-1:0] clr_mask;
  logic [N_LINES-1:0] pend_reg;
  logic [N_LINES-1:0] pend_next;
  logic [CODE_W-1:0]  code_reg;
  logic               valid_reg;
  logic               gs_n_reg;
  state_t             state_reg;
  logic [CODE_W-1:0]  grant_idx;
  logic               grant_any;
  logic               grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= SYNC_RST;
      end
      prev_reg <= SYNC_RST;
    end else begin
      sync_reg[0] <= bus.req_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
      prev_reg <= sync_q;
    end
  end

  assign sync_q = sync_reg[SYNC_STAGES-1];

  assign grant = (state_reg == IDLE) && bus.en && grant_any;

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_line
      assign fall[gi]     = bus.en & ~sync_q[gi] & prev_reg[gi];
      assign clr_mask[gi] = grant && (grant_idx == CODE_W'(gi));
    end
  endgenerate

  // A fresh edge on the line being granted re-arms it in the same cycle.
  assign pend_next = (pend_reg & ~clr_mask) | fall;

`ifdef ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= CODE_W'(N_LINES - 1);
    end else if (grant) begin
      ptr_reg <= grant_idx;
    end
  end

  pri_enc16 #(.ASCENDING(1'b1)) u_pri (
    .pend  (pend_reg),
    .start (ptr_reg + CODE_W'(1)),
    .index (grant_idx),
    .any   (grant_any)
  );
`else
  pri_enc16 #(.ASCENDING(1'b0)) u_pri (
    .pend  (pend_reg),
    .start (CODE_W'(N_LINES - 1)),
    .index (grant_idx),
    .any   (grant_any)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      code_reg  <= '0;
      valid_reg <= 1'b0;
      pend_reg  <= '0;
      gs_n_reg  <= 1'b1;
    end else begin
      pend_reg <= pend_next;
      gs_n_reg <= ~|pend_next;
      case (state_reg)
        IDLE: begin
          if (grant) begin
            code_reg  <= grant_idx;
            valid_reg <= 1'b1;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.code  = code_reg;
  assign bus.valid = valid_reg;
  assign bus.gs_n  = gs_n_reg;
  assign bus.pend  = pend_reg;

endmodule

// File: tb/tb_enc16to4_low.sv
// Scoreboard bench for enc16to4_low: expected codes queued at stimulus, popped on each handshake.
module tb_enc16to4_low;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sb[$];
  int   grant_cyc[$];

  enc16to4_low_if bus ();

  enc16to4_low #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (bus.valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    if (bus.valid !== 1'b1) chk(tag, 32'(bus.valid), 32'd1);
  endtask

  // Handshake completes on the next rising edge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.valid === 1'b1 && bus.ack === 1'b1) begin
      grant_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_grant", 32'(bus.code), 32'hFFFF);
      end else begin
        int exp_code;
        exp_code = sb.pop_front();
        $display("grant code=%0d expected=%0d cycle=%0d", bus.code, exp_code, cyc);
        chk("grant_code", 32'(bus.code), 32'(exp_code));
      end
    end
  end

  initial begin
    bus.en    = 1'b1;
    bus.req_n = 16'hFFFF;
    bus.ack   = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("rst_pend", 32'(bus.pend), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_gs_n", 32'(bus.gs_n), 32'd1);
      chk("rst_code", 32'(bus.code), 32'd0);
    end

    // Single request on line 5
    bus.req_n[5] = 1'b0;
    sb.push_back(5);
    tick(3);
    chk("single_pend5", 32'(bus.pend[5]), 32'd1);
    chk("single_gs_n", 32'(bus.gs_n), 32'd0);
    chk("single_valid_early", 32'(bus.valid), 32'd0);
    tick(1);
    chk("single_valid", 32'(bus.valid), 32'd1);
    chk("single_code", 32'(bus.code), 32'd5);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("single_hold_valid", 32'(bus.valid), 32'd1);
      chk("single_hold_pend5", 32'(bus.pend[5]), 32'd0);
    end
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    chk("single_ack_valid", 32'(bus.valid), 32'd0);
    chk("single_ack_gs_n", 32'(bus.gs_n), 32'd1);
    bus.req_n[5] = 1'b1;
    tick(4);

    // Simultaneous requests on 3, 9, 12 with ack held high
    do_reset();
    grant_cyc.delete();
    bus.ack = 1'b1;
    bus.req_n[3] = 1'b0;
    bus.req_n[9] = 1'b0;
    bus.req_n[12] = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
    sb.push_back(3); sb.push_back(9); sb.push_back(12);
`else
    sb.push_back(12); sb.push_back(9); sb.push_back(3);
`endif
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
    chk("multi_drain", 32'(sb.size()), 32'd0);
    chk("multi_count", 32'(grant_cyc.size()), 32'd3);
    if (grant_cyc.size() >= 3) begin
      chk("multi_gap1", 32'(grant_cyc[1] - grant_cyc[0]), 32'd2);
      chk("multi_gap2", 32'(grant_cyc[2] - grant_cyc[1]), 32'd2);
    end
    bus.ack = 1'b0;
    bus.req_n = 16'hFFFF;
    tick(4);

    // Enable gating on line 7
    do_reset();
    bus.en = 1'b0;
    bus.req_n[7] = 1'b0;
    tick(6);
    chk("en0_pend", 32'(bus.pend), 32'd0);
    chk("en0_valid", 32'(bus.valid), 32'd0);
    bus.en = 1'b1;
    tick(6);
    chk("en1_low_pend", 32'(bus.pend), 32'd0);
    chk("en1_low_valid", 32'(bus.valid), 32'd0);
    chk("en1_low_gs_n", 32'(bus.gs_n), 32'd1);
    bus.req_n[7] = 1'b1;
    tick(4);
    bus.req_n[7] = 1'b0;
    sb.push_back(7);
    wait_valid("en_reedge_timeout", 10);
    chk("en_reedge_code", 32'(bus.code), 32'd7);
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    chk("en_reedge_done", 32'(bus.valid), 32'd0);
    bus.req_n[7] = 1'b1;
    tick(4);

    // Reset mid-grant
    do_reset();
    bus.req_n[4] = 1'b0;
    wait_valid("midrst_timeout", 10);
    chk("midrst_code4", 32'(bus.code), 32'd4);
    bus.req_n[2] = 1'b0;
    tick(3);
    chk("midrst_pend2", 32'(bus.pend[2]), 32'd1);
    chk("midrst_valid", 32'(bus.valid), 32'd1);
    bus.req_n = 16'hFFFF;
    rst_n = 1'b0;
    #1;
    chk("midrst_pend_clr", 32'(bus.pend), 32'd0);
    chk("midrst_valid_clr", 32'(bus.valid), 32'd0);
    chk("midrst_gs_n", 32'(bus.gs_n), 32'd1);
    chk("midrst_code_clr", 32'(bus.code), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("post_rst_valid", 32'(bus.valid), 32'd0);
    end
    chk("post_rst_pend", 32'(bus.pend), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
